// File: rtl/vector_normalize.sv
// vector_normalize: u = x / n for a signed Q16.16 vector, giving Q2.30 components through
// bit-serial restoring division. Define VECTOR_NORMALIZE_ROUND_EN for round-to-nearest results.
module vector_normalize (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic [31:0] n,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] u1,
   output logic [31:0] u2,
   output logic        div0,
   output logic        sat,
   output logic [1:0]  o_dbg_state
);

`ifdef VECTOR_NORMALIZE_ROUND_EN
   localparam int QW = 32;
`else
   localparam int QW = 31;
`endif
   localparam logic [4:0] CNT_LOAD = 5'(QW - 1);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
   // the producer holds its payload and valid steady until that edge.
   typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;
   state_t r_state, w_state_nxt;

   logic [4:0]    r_cnt;
   logic [31:0]   r_n;
   logic          r_neg1, r_neg2, r_sat1, r_sat2;
   logic [32:0]   r_rem1, r_rem2;
   logic [QW-2:0] r_q1, r_q2;
   logic [31:0]   r_u1, r_u2;
   logic          r_div0, r_sat;

   logic [31:0]   w_mag1, w_mag2;
   logic          w_in_sat1, w_in_sat2, w_n_zero, w_skip, w_last;
   logic          w_ge1, w_ge2;
   logic [31:0]   w_sub1, w_sub2, w_keep1, w_keep2;
   logic [QW-1:0] w_q1, w_q2;
   logic [31:0]   w_qmag1, w_qmag2;
   logic          w_ovf1, w_ovf2;
   logic [31:0]   w_fin1, w_fin2;

   function automatic logic [31:0] f_apply(input logic neg, input logic forced,
                                           input logic [31:0] mag);
      logic [31:0] m;
      m = forced ? 32'h7FFF_FFFF : mag;
      return neg ? (~m + 32'd1) : m;
   endfunction

   // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
   assign w_mag1    = x1[31] ? (~x1 + 32'd1) : x1;
   assign w_mag2    = x2[31] ? (~x2 + 32'd1) : x2;
   assign w_in_sat1 = {1'b0, w_mag1} >= {n, 1'b0};
   assign w_in_sat2 = {1'b0, w_mag2} >= {n, 1'b0};
   assign w_n_zero  = (n == 32'd0);
   assign w_skip    = w_n_zero | (w_in_sat1 & w_in_sat2);
   assign w_last    = (r_cnt == 5'd0);

   // Partial remainder stays below n after each step, so 32 bits hold it before the shift.
   assign w_ge1   = r_rem1 >= {1'b0, r_n};
   assign w_ge2   = r_rem2 >= {1'b0, r_n};
   assign w_sub1  = r_rem1[31:0] - r_n;
   assign w_sub2  = r_rem2[31:0] - r_n;
   assign w_keep1 = w_ge1 ? w_sub1 : r_rem1[31:0];
   assign w_keep2 = w_ge2 ? w_sub2 : r_rem2[31:0];
   assign w_q1    = {r_q1, w_ge1};
   assign w_q2    = {r_q2, w_ge2};

`ifdef VECTOR_NORMALIZE_ROUND_EN
   assign w_qmag1 = {1'b0, w_q1[31:1]} + {31'd0, w_q1[0]};
   assign w_qmag2 = {1'b0, w_q2[31:1]} + {31'd0, w_q2[0]};
   assign w_ovf1  = w_qmag1[31];
   assign w_ovf2  = w_qmag2[31];
`else
   assign w_qmag1 = {1'b0, w_q1};
   assign w_qmag2 = {1'b0, w_q2};
   assign w_ovf1  = 1'b0;
   assign w_ovf2  = 1'b0;
`endif

   assign w_fin1 = f_apply(r_neg1, r_sat1 | w_ovf1, w_qmag1);
   assign w_fin2 = f_apply(r_neg2, r_sat2 | w_ovf2, w_qmag2);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = w_skip ? DONE : DIV;
         DIV:     if (w_last) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= 5'd0;
         r_n    <= 32'd0;
         r_neg1 <= 1'b0;
         r_neg2 <= 1'b0;
         r_sat1 <= 1'b0;
         r_sat2 <= 1'b0;
         r_rem1 <= 33'd0;
         r_rem2 <= 33'd0;
         r_q1   <= '0;
         r_q2   <= '0;
         r_u1   <= 32'd0;
         r_u2   <= 32'd0;
         r_div0 <= 1'b0;
         r_sat  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_n    <= n;
                  r_neg1 <= x1[31];
                  r_neg2 <= x2[31];
                  r_sat1 <= w_in_sat1;
                  r_sat2 <= w_in_sat2;
                  r_rem1 <= {1'b0, w_mag1};
                  r_rem2 <= {1'b0, w_mag2};
                  r_q1   <= '0;
                  r_q2   <= '0;
                  r_cnt  <= CNT_LOAD;
                  if (w_n_zero) begin
                     r_u1   <= 32'd0;
                     r_u2   <= 32'd0;
                     r_div0 <= 1'b1;
                     r_sat  <= 1'b0;
                  end else if (w_skip) begin
                     r_u1   <= f_apply(x1[31], 1'b1, 32'd0);
                     r_u2   <= f_apply(x2[31], 1'b1, 32'd0);
                     r_div0 <= 1'b0;
                     r_sat  <= 1'b1;
                  end
               end
            end
            DIV: begin
               r_rem1 <= {w_keep1, 1'b0};
               r_rem2 <= {w_keep2, 1'b0};
               r_q1   <= w_q1[QW-2:0];
               r_q2   <= w_q2[QW-2:0];
               if (w_last) begin
                  r_u1   <= w_fin1;
                  r_u2   <= w_fin2;
                  r_div0 <= 1'b0;
                  r_sat  <= r_sat1 | r_sat2 | w_ovf1 | w_ovf2;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign u1          = r_u1;
   assign u2          = r_u2;
   assign div0        = r_div0;
   assign sat         = r_sat;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vector_normalize.sv
// Bench for vector_normalize: directed vectors, handshake/hold/reset scenarios and random
// vectors scored against an arithmetic reference model.
module tb_vector_normalize;

`ifdef VECTOR_NORMALIZE_ROUND_EN
   localparam int DIV_LAT = 33;
   localparam bit ROUND   = 1'b1;
`else
   localparam int DIV_LAT = 32;
   localparam bit ROUND   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] x1 = 32'd0;
   logic [31:0] x2 = 32'd0;
   logic [31:0] n = 32'd0;
   logic        in_ready, out_valid, div0, sat;
   logic [31:0] u1, u2;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad = 0;
   logic [65:0] exp_q[$];

   vector_normalize dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .x2(x2), .n(n), .out_valid(out_valid), .out_ready(out_ready),
      .u1(u1), .u2(u2), .div0(div0), .sat(sat), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Returns {saturated_by_magnitude, sat, u} for one component with n != 0.
   function automatic logic [33:0] ref_comp(input logic [31:0] x, input logic [31:0] nn);
      longint      sx;
      logic [63:0] ax, q, nn64;
      logic [31:0] u;
      logic        s;
      sx   = longint'($signed(x));
      ax   = (sx < 0) ? 64'(-sx) : 64'(sx);
      nn64 = {32'd0, nn};
      if (ax >= 2 * nn64) begin
         u = (sx < 0) ? 32'h8000_0001 : 32'h7FFF_FFFF;
         return {1'b1, 1'b1, u};
      end
      s = 1'b0;
      if (ROUND) begin
         q = ((ax << 31) / nn64 + 64'd1) / 64'd2;
         if (q > 64'h7FFF_FFFF) begin
            q = 64'h7FFF_FFFF;
            s = 1'b1;
         end
      end else begin
         q = (ax << 30) / nn64;
      end
      u = (sx < 0) ? (32'd0 - q[31:0]) : q[31:0];
      return {1'b0, s, u};
   endfunction

   function automatic void expect_vec(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] nn, output logic [65:0] e,
                                      output int lat);
      logic [33:0] r1, r2;
      if (nn == 32'd0) begin
         e   = {32'd0, 32'd0, 1'b1, 1'b0};
         lat = 1;
      end else begin
         r1  = ref_comp(a, nn);
         r2  = ref_comp(b, nn);
         e   = {r1[31:0], r2[31:0], 1'b0, r1[32] | r2[32]};
         lat = (r1[33] & r2[33]) ? 1 : DIV_LAT;
      end
   endfunction

   // Offers one vector from IDLE, waits for the result, then completes the output handshake.
   task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] nn,
                          output logic [65:0] obs, output int lat);
      int guard;
      guard = 0;
      x1 = a; x2 = b; n = nn; in_valid = 1'b1; out_ready = 1'b0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = 999;
      obs = {u1, u2, div0, sat};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (u1 !== 32'd0) begin bad++; $display("FAIL reset_u1: got %h want 0", u1); end
      total++; if (u2 !== 32'd0) begin bad++; $display("FAIL reset_u2: got %h want 0", u2); end
      total++; if (div0 !== 1'b0) begin bad++; $display("FAIL reset_div0: got %b want 0", div0); end
      total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", sat); end
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_spec_vectors();
      logic [31:0] va[5], vb[5], vn[5], e1[5], e2[5];
      logic        ed[5], es[5];
      int          el[5];
      logic [65:0] obs;
      int          lat;
      va = '{32'h0003_0000, 32'hFFFD_0000, 32'h0002_0000, 32'h1234_ABCD, 32'h000A_0000};
      vb = '{32'h0004_0000, 32'h0004_0000, 32'h0002_0000, 32'hFEDC_0000, 32'hFFF6_0000};
      vn = '{32'h0005_0000, 32'h0005_0000, 32'h0003_0000, 32'h0000_0000, 32'h0001_0000};
      e1 = '{32'h2666_6666, 32'hD999_999A, ROUND ? 32'h2AAA_AAAB : 32'h2AAA_AAAA, 32'd0, 32'h7FFF_FFFF};
      e2 = '{32'h3333_3333, 32'h3333_3333, ROUND ? 32'h2AAA_AAAB : 32'h2AAA_AAAA, 32'd0, 32'h8000_0001};
      ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      el = '{DIV_LAT, DIV_LAT, DIV_LAT, 1, 1};
      for (int i = 0; i < 5; i++) begin
         run_vec(va[i], vb[i], vn[i], obs, lat);
         total++; if (obs[65:34] !== e1[i]) begin bad++; $display("FAIL spec_u1[%0d]: got %h want %h", i, obs[65:34], e1[i]); end
         total++; if (obs[33:2] !== e2[i]) begin bad++; $display("FAIL spec_u2[%0d]: got %h want %h", i, obs[33:2], e2[i]); end
         total++; if (obs[1] !== ed[i]) begin bad++; $display("FAIL spec_div0[%0d]: got %b want %b", i, obs[1], ed[i]); end
         total++; if (obs[0] !== es[i]) begin bad++; $display("FAIL spec_sat[%0d]: got %b want %b", i, obs[0], es[i]); end
         total++; if (lat !== el[i]) begin bad++; $display("FAIL spec_latency[%0d]: got %0d want %0d", i, lat, el[i]); end
      end
   endtask

   // n == 0 with both valid and ready held high: accept, present, release, accept again.
   task automatic test_back_to_back();
      logic [1:0] exp_vr;
      x1 = $urandom; x2 = $urandom; n = 32'd0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         exp_vr = (i % 2 == 0) ? 2'b10 : 2'b01;
         total++;
         if ({out_valid, in_ready} !== exp_vr) begin
            bad++; $display("FAIL b2b_handshake[%0d]: got %b want %b", i, {out_valid, in_ready}, exp_vr);
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_hold();
      logic [65:0] e_a, e_b, cap;
      int          lat_a, lat_b, lat;
      expect_vec(32'h0003_0000, 32'h0004_0000, 32'h0005_0000, e_a, lat_a);
      expect_vec(32'hFFFD_0000, 32'h0004_0000, 32'h0005_0000, e_b, lat_b);
      x1 = 32'h0003_0000; x2 = 32'h0004_0000; n = 32'h0005_0000;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      x1 = 32'hFFFD_0000;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      cap = {u1, u2, div0, sat};
      total++; if (cap !== e_a) begin bad++; $display("FAIL hold_first: got %h want %h", cap, e_a); end
      total++; if (lat !== lat_a) begin bad++; $display("FAIL hold_latency: got %0d want %0d", lat, lat_a); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if ({out_valid, in_ready, u1, u2, div0, sat} !== {1'b1, 1'b0, e_a}) begin
            bad++; $display("FAIL hold_stable[%0d]: got %b%b_%h want 10_%h", i, out_valid, in_ready, {u1, u2, div0, sat}, e_a);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      total++; if ({u1, u2, div0, sat} !== e_b) begin bad++; $display("FAIL hold_second: got %h want %h", {u1, u2, div0, sat}, e_b); end
      total++; if (lat !== lat_b) begin bad++; $display("FAIL hold_second_latency: got %0d want %0d", lat, lat_b); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_div();
      logic [65:0] e, obs;
      int          el, lat;
      bit          seen;
      x1 = 32'h0003_0000; x2 = 32'h0004_0000; n = 32'h0005_0000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({out_valid, u1, u2, div0, sat} !== 67'd0) begin
         bad++; $display("FAIL midreset_outputs: got %b_%h want 0", out_valid, {u1, u2, div0, sat});
      end
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL midreset_ready: got %b want 10", {in_ready, out_valid}); end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_aborted_result: got %b want 0", seen); end
      expect_vec(32'h0002_0000, 32'h0002_0000, 32'h0003_0000, e, el);
      run_vec(32'h0002_0000, 32'h0002_0000, 32'h0003_0000, obs, lat);
      total++; if (obs !== e) begin bad++; $display("FAIL midreset_next: got %h want %h", obs, e); end
      total++; if (lat !== el) begin bad++; $display("FAIL midreset_next_latency: got %0d want %0d", lat, el); end
   endtask

   task automatic test_random();
      logic [31:0] a, b, nn;
      logic [65:0] e, obs;
      int          el, lat, sel;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0: begin a = $urandom; b = $urandom; nn = 32'd0; end
            1: begin a = $urandom; b = $urandom; nn = $urandom; end
            2: begin
               nn = $urandom_range(1, 32'h000F_FFFF);
               a = $urandom_range(0, 2 * nn - 1);
               b = $urandom_range(0, 2 * nn - 1);
               if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
               if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            end
            3: begin
               a = 32'h8000_0000; b = $urandom;
               nn = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h4000_0000;
            end
            4: begin nn = $urandom_range(1, 32'h0000_FFFF); a = nn * 4; b = $urandom_range(0, nn); end
            default: begin nn = $urandom_range(1, 32'h7FFF_FFFF); a = nn; b = 32'd0 - nn; end
         endcase
         if (nn == 32'd0 && sel != 0) nn = 32'd1;
         expect_vec(a, b, nn, e, el);
         exp_q.push_back(e);
         run_vec(a, b, nn, obs, lat);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL rand_result[%0d] x1=%h x2=%h n=%h: got %h want %h", i, a, b, nn, obs, e);
         end
         total++; if (lat !== el) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, el); end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_spec_vectors();
      test_back_to_back();
      test_hold();
      test_reset_mid_div();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
